// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Round-robin, packet-aware arbiter that shares one UART transmit
//             byte interface among N_REQ valid/ready byte sources. A grant is
//             held until a byte with last set is sent, or until MAX_BURST
//             bytes have been sent (MAX_BURST=0 means no burst limit).
//  Ports    : clk, rst (sync, active-high)
//             req_valid/req_data/req_last  - per-requester byte streams in
//             req_ready                    - per-requester accept out
//             tx_data_valid/tx_data        - to UART transmitter
//             tx_data_ready                - from UART transmitter
//             grant_id                     - current/most recent grantee
//             busy                         - high while a grant is held
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16,
  parameter int GW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tx_data_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_data_ready,
  output logic [GW-1:0]        grant_id,
  output logic                 busy
);

  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

  logic [7:0]      req_bytes [N_REQ];

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign req_bytes[i] = req_data[8*i +: 8];
    end
  endgenerate

  // Round-robin scan starting at rr_ptr. The wrap is an explicit compare so
  // that non-power-of-two requester counts wrap at N_REQ, not at 2**GW.
  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic [GW:0]   cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (GW+1)'(k);
      if (cand >= (GW+1)'(N_REQ)) begin
        cand = cand - (GW+1)'(N_REQ);
      end
      if (!pick_found && req_valid[cand[GW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[GW-1:0];
      end
    end
  end

  // Granted-requester view and transfer/release qualification.
  logic       g_valid;
  logic       g_last;
  logic [7:0] g_data;
  logic       xfer;
  logic       burst_done;
  logic       release_now;

  always_comb begin
    g_valid     = req_valid[grant_id_q];
    g_last      = req_last[grant_id_q];
    g_data      = req_bytes[grant_id_q];
    xfer        = (state_q == ST_GRANT) && g_valid && tx_data_ready;
    burst_done  = (MAX_BURST != 0) &&
                  (({1'b0, beat_cnt_q} + 1'b1) == (BW+1)'(MAX_BURST));
    release_now = xfer && (g_last || burst_done);
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d    = ST_GRANT;
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          // The released requester becomes lowest priority next time.
          state_d    = ST_IDLE;
          beat_cnt_d = '0;
          rr_ptr_d   = (grant_id_q == GW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        end else if (xfer && (MAX_BURST != 0)) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are forced low while rst is high so that a byte offered in the
  // reset cycle is never accepted.
  always_comb begin
    req_ready     = '0;
    tx_data_valid = 1'b0;
    tx_data       = '0;
    busy          = 1'b0;
    grant_id      = rst ? '0 : grant_id_q;
    if (!rst && (state_q == ST_GRANT)) begin
      busy                  = 1'b1;
      tx_data_valid         = g_valid;
      tx_data               = g_data;
      req_ready[grant_id_q] = tx_data_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  a_ready_onehot0: assert property (@(posedge clk) $onehot0(req_ready));

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin, packet-aware arbiter that shares the single UART host transmit interface among N_REQ requesters.
- Each requester presents a valid/ready byte stream with a last flag.
- A granted requester keeps the transmitter until it sends a byte with last set, or until it has sent MAX_BURST bytes.
- Sits between host-side byte sources (debug console, status reporter, command responder) and the uart top-level tx_data_valid/tx_data/tx_data_ready inputs.

Parameters:
N_REQ, 4, number of requesters (1..16).
MAX_BURST, 16, max bytes per grant before forced release; 0 = unlimited (release only on last).
GW, $clog2(N_REQ) (min 1), width of grant index.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
req_valid  input  N_REQ  per-requester byte valid.
req_data  input  8*N_REQ  per-requester byte; requester i on bits [8i+7:8i].
req_last  input  N_REQ  per-requester end-of-packet flag, qualified by req_valid.
req_ready  output  N_REQ  per-requester byte accepted.
tx_data_valid  output  1  to uart tx_data_valid.
tx_data  output  8  to uart tx_data.
tx_data_ready  input  1  from uart tx_data_ready.
grant_id  output  GW  index of current or most recent granted requester.
busy  output  1  1 while a grant is held.

Behaviour:
- Clock and reset:
  - Single clock domain; reset is synchronous and active-high.
  - rst high at a rising edge sets: state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, busy=0.
  - All outputs are 0 during and after reset until the first grant.
  - Reset mid-packet aborts the grant immediately. A byte presented in the reset cycle is not counted. Requesters are responsible for resuming.
- State machine: IDLE, GRANT.
- IDLE:
  - tx_data_valid=0, tx_data=0, req_ready=0.
  - If any req_valid is high, choose the first i with req_valid[i] high, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N_REQ.
  - At the next edge: grant_id=i, busy=1, beat_cnt=0, state=GRANT.
  - Arbitration latency is exactly 1 cycle from req_valid to the first tx_data_valid.
- GRANT, with g = grant_id (combinational pass-through, no added latency):
  - tx_data_valid = req_valid[g].
  - tx_data = req_data[g].
  - req_ready[g] = tx_data_ready.
  - req_ready[j] = 0 for all j != g.
  - A beat transfers when req_valid[g] && tx_data_ready. On a transfer, beat_cnt increments.
  - Release occurs on a transfer with req_last[g]=1, or on a transfer when MAX_BURST!=0 and beat_cnt+1 == MAX_BURST.
  - On release, at the next edge: state=IDLE, busy=0, rr_ptr=(g+1) mod N_REQ; grant_id keeps its value.
  - If req_valid[g] deasserts mid-packet, the grant is held (no timeout). tx_data_valid follows it to 0.
- Re-arbitration: after release there is one IDLE cycle before the next grant, so back-to-back packets have 1 bubble cycle. The released requester has lowest priority in the next arbitration.
- Simultaneous events: requests from others during GRANT are ignored until release. All ties are resolved by round-robin order from rr_ptr.
- Widths and wrap:
  - beat_cnt is $clog2(MAX_BURST+1) bits (1 bit if MAX_BURST=0) and never wraps, because it clears on release. With MAX_BURST=0 the counter is unused.
  - rr_ptr wraps from N_REQ-1 to 0. For non-power-of-2 N_REQ the wrap uses explicit compare, not bit truncation.
- Valid/ready stability: tx_data_valid/tx_data are stable while valid && !ready, provided the granted requester obeys the same rule. The arbiter never switches grant while a byte is pending.
- Assertion: req_ready is onehot0 every cycle.

Test Plan:
- Reset then single requester 2 sends 3 bytes 0xA1,0xA2,0xA3 (last on 0xA3), tx_data_ready=1 → grant_id=2 one cycle after req_valid; tx_data shows A1,A2,A3 on consecutive cycles; busy drops the cycle after A3; rr_ptr=3.
- All 4 requesters valid continuously with 1-byte packets (last=1), ready=1 → grant order 0,1,2,3,0,1; each byte separated by exactly one idle cycle.
- Requester 1 holds valid with last=0 for 40 bytes, requester 3 also valid, MAX_BURST=16 → 16 bytes from 1, release, then requester 3 granted; requester 1 regranted after 3's packet ends.
- tx_data_ready toggled 0/1 every cycle during a 4-byte packet from requester 0 (0x10..0x13) → tx_data holds each byte while ready=0; exactly 4 transfers; req_ready[1..3] stay 0 throughout.
- Requester 0 drops valid for 5 cycles mid-packet while requester 1 is valid → grant stays 0, tx_data_valid=0 for those 5 cycles, no transfer from requester 1 until requester 0 sends last.
- rst asserted for 1 cycle mid-packet of requester 2 → next cycle state=IDLE, busy=0, grant_id=0, rr_ptr=0; with 0 and 2 both valid, requester 0 is granted next.
